// File: rtl/ucsbece154b_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154b_bp_update_ctrl
// Brief    : In-order branch resolution controller; sequences BTB/PHT updates
//            and drives flush, redirect and GHR restore on mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154b_bp_update_ctrl #(
    parameter int DEPTH           = 4,
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic                               alloc_valid_i,
    output logic                               alloc_ready_o,
    input  logic [31:0]                        alloc_pc_i,
    input  logic                               alloc_taken_i,
    input  logic [31:0]                        alloc_target_i,
    input  logic [NUM_GHR_BITS-1:0]            alloc_phtidx_i,
    input  logic [NUM_GHR_BITS-1:0]            alloc_ghr_i,
    input  logic                               res_valid_i,
    input  logic                               res_taken_i,
    input  logic [31:0]                        res_target_i,
    input  logic                               res_isbranch_i,
    input  logic                               res_isjump_i,
    output logic                               BTBwe_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [31:0]                        BTBwritedata_o,
    output logic                               BTBJ_o,
    output logic                               BTBB_o,
    output logic                               PHTwe_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               PHTincrement_o,
    output logic                               flush_o,
    output logic [31:0]                        redirect_pc_o,
    output logic                               GHRrestore_o,
    output logic [NUM_GHR_BITS-1:0]            GHRrestoreval_o,
    output logic [$clog2(DEPTH):0]             count_o,
    output logic                               err_o
);

    localparam int c_pw = $clog2(DEPTH);
    localparam int c_cw = c_pw + 1;
    localparam int c_bi = $clog2(NUM_BTB_ENTRIES);
    localparam int c_g  = NUM_GHR_BITS;
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t          r_state;
    logic [c_pw-1:0] r_wr_ptr;
    logic [c_pw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            r_err;

    logic [31:0]     r_pc_q     [DEPTH];
    logic            r_taken_q  [DEPTH];
    logic [31:0]     r_target_q [DEPTH];
    logic [c_g-1:0]  r_phtidx_q [DEPTH];
    logic [c_g-1:0]  r_ghr_q    [DEPTH];

    logic            w_alloc;
    logic            w_alloc_do;
    logic            w_res;
    logic            w_mis;
    logic            w_empty_res;
    logic [31:0]     w_head_pc;
    logic            w_head_taken;
    logic [31:0]     w_head_target;
    logic [c_g-1:0]  w_head_phtidx;
    logic [c_g-1:0]  w_head_ghr;

    // Gated by reset so fetch sees "not ready" while the controller is held.
    assign alloc_ready_o = reset_i && (r_state == RUN) && (r_count < c_depth);

    assign w_head_pc     = r_pc_q[r_rd_ptr];
    assign w_head_taken  = r_taken_q[r_rd_ptr];
    assign w_head_target = r_target_q[r_rd_ptr];
    assign w_head_phtidx = r_phtidx_q[r_rd_ptr];
    assign w_head_ghr    = r_ghr_q[r_rd_ptr];

    assign w_alloc     = alloc_valid_i && alloc_ready_o;
    assign w_res       = res_valid_i && (r_state == RUN) && (r_count != '0);
    assign w_empty_res = res_valid_i && (r_state == RUN) && (r_count == '0);
    assign w_mis       = (w_head_taken != res_taken_i) ||
                         (res_taken_i && (w_head_target != res_target_i));
    // Anything fetched alongside a mispredicting resolve is wrong-path.
    assign w_alloc_do  = w_alloc && !(w_res && w_mis);

    always_ff @(posedge clk) begin
        if (w_alloc_do) begin
            r_pc_q[r_wr_ptr]     <= alloc_pc_i;
            r_taken_q[r_wr_ptr]  <= alloc_taken_i;
            r_target_q[r_wr_ptr] <= alloc_target_i;
            r_phtidx_q[r_wr_ptr] <= alloc_phtidx_i;
            r_ghr_q[r_wr_ptr]    <= alloc_ghr_i;
        end
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_state           <= RUN;
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_count           <= '0;
            r_err             <= 1'b0;
            BTBwe_o           <= 1'b0;
            BTBwriteaddress_o <= '0;
            BTBwritedata_o    <= '0;
            BTBJ_o            <= 1'b0;
            BTBB_o            <= 1'b0;
            PHTwe_o           <= 1'b0;
            PHTwriteaddress_o <= '0;
            PHTincrement_o    <= 1'b0;
            flush_o           <= 1'b0;
            redirect_pc_o     <= '0;
            GHRrestore_o      <= 1'b0;
            GHRrestoreval_o   <= '0;
        end else begin
            BTBwe_o      <= 1'b0;
            PHTwe_o      <= 1'b0;
            flush_o      <= 1'b0;
            GHRrestore_o <= 1'b0;

            if (w_empty_res) begin
                r_err <= 1'b1;
            end

            case (r_state)
                RUN: begin
                    if (w_res && w_mis) begin
                        r_state  <= RECOVER;
                        r_wr_ptr <= '0;
                        r_rd_ptr <= '0;
                        r_count  <= '0;
                    end else begin
                        if (w_alloc_do) begin
                            r_wr_ptr <= r_wr_ptr + c_pw'(1);
                        end
                        if (w_res) begin
                            r_rd_ptr <= r_rd_ptr + c_pw'(1);
                        end
                        r_count <= r_count + c_cw'(w_alloc_do) - c_cw'(w_res);
                    end
                end
                RECOVER: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase

            if (w_res) begin
                PHTwe_o           <= res_isbranch_i;
                PHTwriteaddress_o <= w_head_phtidx;
                PHTincrement_o    <= res_taken_i;
                BTBwe_o           <= res_taken_i && (res_isbranch_i || res_isjump_i);
                BTBwriteaddress_o <= w_head_pc[c_bi+1:2];
                BTBwritedata_o    <= res_target_i;
                BTBJ_o            <= res_isjump_i;
                BTBB_o            <= res_isbranch_i;
                if (w_mis) begin
                    flush_o         <= 1'b1;
                    redirect_pc_o   <= res_taken_i ? res_target_i : (w_head_pc + 32'd4);
                    GHRrestore_o    <= 1'b1;
                    GHRrestoreval_o <= {w_head_ghr[c_g-2:0], res_taken_i};
                end
            end
        end
    end

    assign count_o = r_count;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154b_bp_update_ctrl
// Brief    : Directed self-checking bench for the branch update controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154b_bp_update_ctrl;

    logic        clk;
    logic        reset_i;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [31:0] alloc_pc_i;
    logic        alloc_taken_i;
    logic [31:0] alloc_target_i;
    logic [4:0]  alloc_phtidx_i;
    logic [4:0]  alloc_ghr_i;
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        res_isbranch_i;
    logic        res_isjump_i;
    logic        BTBwe_o;
    logic [4:0]  BTBwriteaddress_o;
    logic [31:0] BTBwritedata_o;
    logic        BTBJ_o;
    logic        BTBB_o;
    logic        PHTwe_o;
    logic [4:0]  PHTwriteaddress_o;
    logic        PHTincrement_o;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic        GHRrestore_o;
    logic [4:0]  GHRrestoreval_o;
    logic [2:0]  count_o;
    logic        err_o;

    int total;
    int bad;

    ucsbece154b_bp_update_ctrl #(
        .DEPTH(4), .NUM_BTB_ENTRIES(32), .NUM_GHR_BITS(5)
    ) dut (
        .clk(clk), .reset_i(reset_i),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_pc_i(alloc_pc_i), .alloc_taken_i(alloc_taken_i),
        .alloc_target_i(alloc_target_i), .alloc_phtidx_i(alloc_phtidx_i),
        .alloc_ghr_i(alloc_ghr_i),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i),
        .res_target_i(res_target_i), .res_isbranch_i(res_isbranch_i),
        .res_isjump_i(res_isjump_i),
        .BTBwe_o(BTBwe_o), .BTBwriteaddress_o(BTBwriteaddress_o),
        .BTBwritedata_o(BTBwritedata_o), .BTBJ_o(BTBJ_o), .BTBB_o(BTBB_o),
        .PHTwe_o(PHTwe_o), .PHTwriteaddress_o(PHTwriteaddress_o),
        .PHTincrement_o(PHTincrement_o),
        .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
        .GHRrestore_o(GHRrestore_o), .GHRrestoreval_o(GHRrestoreval_o),
        .count_o(count_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                            input logic [4:0] ph, input logic [4:0] gh);
        alloc_valid_i  = 1'b1;
        alloc_pc_i     = pc;
        alloc_taken_i  = tk;
        alloc_target_i = tgt;
        alloc_phtidx_i = ph;
        alloc_ghr_i    = gh;
    endtask

    task automatic do_res(input logic tk, input logic [31:0] tgt, input logic br, input logic jp);
        res_valid_i    = 1'b1;
        res_taken_i    = tk;
        res_target_i   = tgt;
        res_isbranch_i = br;
        res_isjump_i   = jp;
    endtask

    // Advance one edge, then sample 1 time unit later with valids dropped.
    task automatic tick();
        @(posedge clk);
        #1;
        alloc_valid_i = 1'b0;
        res_valid_i   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_i = 1'b0;
        alloc_valid_i = 1'b0; alloc_pc_i = '0; alloc_taken_i = 1'b0; alloc_target_i = '0;
        alloc_phtidx_i = '0; alloc_ghr_i = '0;
        res_valid_i = 1'b0; res_taken_i = 1'b0; res_target_i = '0;
        res_isbranch_i = 1'b0; res_isjump_i = 1'b0;

        tick(); tick();
        chk("rst_ready", alloc_ready_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_btbwe", BTBwe_o, 0);
        chk("rst_phtwe", PHTwe_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_redir", redirect_pc_o, 0);
        reset_i = 1'b1;
        #1;
        chk("post_rst_ready", alloc_ready_o, 1);

        // Correctly predicted not-taken branch
        do_alloc(32'h100, 1'b0, 32'h0, 5'd3, 5'd0);
        tick();
        chk("t1_count_alloc", count_o, 1);
        do_res(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("t1_phtwe", PHTwe_o, 1);
        chk("t1_phtaddr", PHTwriteaddress_o, 3);
        chk("t1_phtinc", PHTincrement_o, 0);
        chk("t1_btbwe", BTBwe_o, 0);
        chk("t1_flush", flush_o, 0);
        chk("t1_ghrr", GHRrestore_o, 0);
        chk("t1_count", count_o, 0);
        tick();
        chk("t1_phtwe_pulse", PHTwe_o, 0);

        // Direction mispredict on a branch
        do_alloc(32'h200, 1'b0, 32'h0, 5'd7, 5'b00101);
        tick();
        do_res(1'b1, 32'h240, 1'b1, 1'b0);
        tick();
        chk("t2_flush", flush_o, 1);
        chk("t2_redir", redirect_pc_o, 32'h240);
        chk("t2_ghrr", GHRrestore_o, 1);
        chk("t2_ghrval", GHRrestoreval_o, 5'b01011);
        chk("t2_btbwe", BTBwe_o, 1);
        chk("t2_btbaddr", BTBwriteaddress_o, 0);
        chk("t2_btbdata", BTBwritedata_o, 32'h240);
        chk("t2_btbb", BTBB_o, 1);
        chk("t2_btbj", BTBJ_o, 0);
        chk("t2_phtinc", PHTincrement_o, 1);
        chk("t2_ready_recover", alloc_ready_o, 0);
        tick();
        chk("t2_flush_pulse", flush_o, 0);
        chk("t2_ready_back", alloc_ready_o, 1);

        // Jump target mispredict
        do_alloc(32'h30, 1'b1, 32'h80, 5'd1, 5'd0);
        tick();
        do_res(1'b1, 32'h90, 1'b0, 1'b1);
        tick();
        chk("t3_flush", flush_o, 1);
        chk("t3_redir", redirect_pc_o, 32'h90);
        chk("t3_btbj", BTBJ_o, 1);
        chk("t3_btbaddr", BTBwriteaddress_o, 12);
        chk("t3_phtwe", PHTwe_o, 0);
        chk("t3_ghrval", GHRrestoreval_o, 5'b00001);
        tick();

        // Correctly predicted jump still writes the BTB
        do_alloc(32'h44, 1'b1, 32'h80, 5'd2, 5'd0);
        tick();
        do_res(1'b1, 32'h80, 1'b0, 1'b1);
        tick();
        chk("t3b_flush", flush_o, 0);
        chk("t3b_btbwe", BTBwe_o, 1);
        chk("t3b_btbaddr", BTBwriteaddress_o, 17);

        // Predicted taken, actually not taken: redirect to pc+4 with wrap
        do_alloc(32'hFFFF_FFFC, 1'b1, 32'h40, 5'd4, 5'b10000);
        tick();
        do_res(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("t3c_flush", flush_o, 1);
        chk("t3c_redir", redirect_pc_o, 32'h0);
        chk("t3c_ghrval", GHRrestoreval_o, 5'b00000);
        chk("t3c_btbwe", BTBwe_o, 0);
        tick();

        // Fill, full refusal, then pointer wrap
        for (int i = 0; i < 4; i++) begin
            do_alloc(32'h400 + 32'(4 * i), 1'b0, 32'h0, 5'(i), 5'd0);
            tick();
        end
        chk("t4_full_count", count_o, 4);
        chk("t4_full_ready", alloc_ready_o, 0);
        do_alloc(32'h500, 1'b0, 32'h0, 5'd30, 5'd0);
        do_res(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("t4_refused_count", count_o, 3);
        chk("t4_ready", alloc_ready_o, 1);
        chk("t4_phtaddr", PHTwriteaddress_o, 0);
        for (int k = 0; k < 10; k++) begin
            do_alloc(32'h600 + 32'(4 * k), 1'b0, 32'h0, 5'(k + 8), 5'd0);
            do_res(1'b0, 32'h0, 1'b1, 1'b0);
            tick();
            chk("t4_wrap_phtaddr", PHTwriteaddress_o, (k < 3) ? 32'(k + 1) : 32'(k + 5));
            chk("t4_wrap_count", count_o, 3);
        end
        for (int k = 0; k < 3; k++) begin
            do_res(1'b0, 32'h0, 1'b1, 1'b0);
            tick();
            chk("t4_drain_phtaddr", PHTwriteaddress_o, 32'(15 + k));
        end
        chk("t4_drain_count", count_o, 0);

        // Mispredict with younger entries and a simultaneous alloc
        do_alloc(32'h700, 1'b0, 32'h0, 5'd5, 5'b11111); tick();
        do_alloc(32'h704, 1'b0, 32'h0, 5'd6, 5'd0);     tick();
        do_alloc(32'h708, 1'b0, 32'h0, 5'd7, 5'd0);     tick();
        chk("t5_count3", count_o, 3);
        do_alloc(32'h900, 1'b0, 32'h0, 5'd9, 5'd0);
        do_res(1'b1, 32'h800, 1'b1, 1'b0);
        tick();
        chk("t5_flush", flush_o, 1);
        chk("t5_redir", redirect_pc_o, 32'h800);
        chk("t5_ghrval", GHRrestoreval_o, 5'b11111);
        chk("t5_count", count_o, 0);
        do_alloc(32'hA00, 1'b0, 32'h0, 5'd1, 5'd0);
        do_res(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        chk("t5_recover_err", err_o, 0);
        chk("t5_recover_phtwe", PHTwe_o, 0);
        chk("t5_recover_count", count_o, 0);

        // Resolve while empty
        do_res(1'b1, 32'h0, 1'b1, 1'b0);
        tick();
        chk("t6_err", err_o, 1);
        chk("t6_phtwe", PHTwe_o, 0);
        chk("t6_btbwe", BTBwe_o, 0);
        tick();
        chk("t6_err_sticky", err_o, 1);

        // Asynchronous reset mid-stream
        do_alloc(32'hB00, 1'b0, 32'h0, 5'd2, 5'd3);
        tick();
        do_res(1'b1, 32'hC00, 1'b1, 1'b0);
        tick();
        chk("t7_flush_before", flush_o, 1);
        reset_i = 1'b0;
        #1;
        chk("t7_flush", flush_o, 0);
        chk("t7_ghrr", GHRrestore_o, 0);
        chk("t7_redir", redirect_pc_o, 0);
        chk("t7_btbwe", BTBwe_o, 0);
        chk("t7_err", err_o, 0);
        chk("t7_count", count_o, 0);
        chk("t7_ready", alloc_ready_o, 0);
        tick();
        reset_i = 1'b1;
        #1;
        chk("t7_ready_after", alloc_ready_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
